// File: rtl/pll_clken_pkg.sv
// pll_clken shared types: FSM state enum and divide/phase clamp helpers.
// The helpers work on 32-bit values so any DIV_W up to 32 can use them.
package pll_clken_pkg;

  typedef enum logic [1:0] {
    PWRDN   = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [31:0] clamp_div(
    input logic [31:0] div
  );
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  function automatic logic [31:0] clamp_phase(
    input logic [31:0] div,
    input logic [31:0] phase
  );
    logic [31:0] d;
    d = clamp_div(div);
    return (phase >= d) ? d - 32'd1 : phase;
  endfunction

endpackage

// File: rtl/pll_clken_if.sv
// pll_clken configuration handshake: valid/ready plus packed
// per-channel divide and phase fields (ch0 in the LSBs).
interface pll_clken_if #(
  parameter int NUM_CH = 6,
  parameter int DIV_W  = 8
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [NUM_CH*DIV_W-1:0]   cfg_div;
  logic [NUM_CH*DIV_W-1:0]   cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/pll_clken_chan.sv
// One divided clock-enable channel; optional duty level output
// under PLL_CLKEN_DUTY_EN.
module pll_clken_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] d,
  input  logic [DIV_W-1:0] p,
  output logic             ce
`ifdef PLL_CLKEN_DUTY_EN
  ,
  output logic             lvl
`endif
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_n;
  logic             run_q;

  // run is next-cycle locked; run_q is current locked, so the
  // first locked cycle always starts at cnt=0
  always_comb begin
    cnt_n = '0;
    if (run && run_q) begin
      if (cnt_q >= d - DIV_W'(1)) cnt_n = '0;
      else cnt_n = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      run_q <= run;
    end
  end

  assign ce = run_q & (cnt_q == p);

`ifdef PLL_CLKEN_DUTY_EN
  logic [DIV_W-1:0] off;
  logic [DIV_W:0]   half;
  logic             win;
  logic             lvl_q;

  always_comb begin
    half = ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
    if (cnt_n >= p) off = cnt_n - p;
    else off = cnt_n + d - p;
    win = ({1'b0, off} < half);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lvl_q <= 1'b0;
    else lvl_q <= run & win;
  end

  assign lvl = lvl_q;
`endif

endmodule

// File: rtl/pll_clken_model.sv
// PLL clock-enable model: lock FSM, config registers, NUM_CH channels.
// Define PLL_CLKEN_DUTY_EN to add the clk_lvl duty-level outputs.
module pll_clken_model
  import pll_clken_pkg::*;
#(
  parameter int NUM_CH      = 6,
  parameter int DIV_W       = 8,
  parameter int DEF_DIV     = 4,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwrdwn,
  input  logic              pll_rst,
  pll_clken_if.slave        cfg,
  output logic              locked,
  output logic [NUM_CH-1:0] ce
`ifdef PLL_CLKEN_DUTY_EN
  ,
  output logic [NUM_CH-1:0] clk_lvl
`endif
);

  localparam int LW =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LW-1:0] LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DEF_D =
    DIV_W'(clamp_div(32'(DEF_DIV)));

  state_t           state_q;
  state_t           state_n;
  logic [LW-1:0]    lock_q;
  logic [LW-1:0]    lock_n;
  logic             accept;
  logic             run;
  logic [DIV_W-1:0] d_q [NUM_CH];
  logic [DIV_W-1:0] p_q [NUM_CH];

  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg.cfg_ready = (state_q != LOCKING);
  assign locked        = (state_q == LOCKED);
  assign run           = (state_n == LOCKED);

  always_comb begin
    state_n = state_q;
    lock_n  = lock_q;
    if (pwrdwn) begin
      state_n = PWRDN;
      lock_n  = '0;
    end else if (state_q == PWRDN) begin
      state_n = LOCKING;
      lock_n  = '0;
    end else if (pll_rst || accept) begin
      state_n = LOCKING;
      lock_n  = '0;
    end else if (state_q == LOCKING) begin
      if (lock_q == LAST) state_n = LOCKED;
      else lock_n = lock_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOCKING;
      lock_q  <= '0;
    end else begin
      state_q <= state_n;
      lock_q  <= lock_n;
    end
  end

  // divide/phase are clamped once here so channels see legal values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d_q[i] <= DEF_D;
        p_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d_q[i] <= DIV_W'(clamp_div(
          32'(cfg.cfg_div[i*DIV_W +: DIV_W])));
        p_q[i] <= DIV_W'(clamp_phase(
          32'(cfg.cfg_div[i*DIV_W +: DIV_W]),
          32'(cfg.cfg_phase[i*DIV_W +: DIV_W])));
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_clken_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .d    (d_q[i]),
      .p    (p_q[i]),
      .ce   (ce[i])
`ifdef PLL_CLKEN_DUTY_EN
      ,
      .lvl  (clk_lvl[i])
`endif
    );
  end

endmodule

// File: tb/tb_pll_clken_model.sv
// Bench for pll_clken_model: directed scenarios then random traffic,
// all checked against a cycle-time arithmetic model of the PLL.
module tb_pll_clken_model;

  localparam int NC = 6;
  localparam int DW = 8;
  localparam int DD = 4;
  localparam int LC = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pwrdwn;
  logic          pll_rst;
  logic          locked;
  logic [NC-1:0] ce;
`ifdef PLL_CLKEN_DUTY_EN
  logic [NC-1:0] clk_lvl;
`endif

  pll_clken_if #(.NUM_CH(NC), .DIV_W(DW)) cfg_if ();

  pll_clken_model #(
    .NUM_CH(NC), .DIV_W(DW),
    .DEF_DIV(DD), .LOCK_CYCLES(LC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwrdwn (pwrdwn),
    .pll_rst(pll_rst),
    .cfg    (cfg_if),
    .locked (locked),
    .ce     (ce)
`ifdef PLL_CLKEN_DUTY_EN
    ,
    .clk_lvl(clk_lvl)
`endif
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 0;
  longint t = 0;
  longint lock_at;
  bit     pd;
  int     md [NC];
  int     mp [NC];

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s t=%0d got %0h want %0h",
                 tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    pd      = 0;
    lock_at = t + 1 + LC;
    for (int i = 0; i < NC; i++) begin
      md[i] = DD;
      mp[i] = 0;
    end
  endtask

  task automatic step();
    bit            le;
    bit            re;
    bit            acc;
    logic [NC-1:0] ce_e;
    logic [NC-1:0] lv_e;
    longint        k;
    int            dv;
    int            ph;
    @(negedge clk);
    le = !pd && (t >= lock_at);
    re = pd || le;
    k  = t - lock_at;
    for (int i = 0; i < NC; i++) begin
      ce_e[i] = le && ((k % md[i]) == mp[i]);
      lv_e[i] = le && ((((k - mp[i]) % md[i]) + md[i])
                       % md[i]) < ((md[i] + 1) / 2);
    end
    if (chk_en) begin
      check("locked", 32'(locked), 32'(le));
      check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(re));
      check("ce", 32'(ce), 32'(ce_e));
`ifdef PLL_CLKEN_DUTY_EN
      check("clk_lvl", 32'(clk_lvl), 32'(lv_e));
`endif
    end
    acc = cfg_if.cfg_valid && re;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (acc) begin
        for (int i = 0; i < NC; i++) begin
          dv = int'(cfg_if.cfg_div[i*DW +: DW]);
          ph = int'(cfg_if.cfg_phase[i*DW +: DW]);
          md[i] = (dv == 0) ? 1 : dv;
          mp[i] = (ph >= md[i]) ? md[i] - 1 : ph;
        end
      end
      if (pwrdwn) pd = 1;
      else if (pd) begin
        pd      = 0;
        lock_at = t + 1 + LC;
      end else if (pll_rst || acc) lock_at = t + 1 + LC;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic cyc(input bit p, input bit r, input bit v,
                     input logic [NC*DW-1:0] dv,
                     input logic [NC*DW-1:0] ph);
    pwrdwn           = p;
    pll_rst          = r;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = dv;
    cfg_if.cfg_phase = ph;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0);
  endtask

  logic [NC*DW-1:0] dvv;
  logic [NC*DW-1:0] phv;
  int               pd_left;

  initial begin
    rst_n   = 0;
    pwrdwn  = 0;
    pll_rst = 0;
    cfg_if.cfg_valid = 0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;
    step();
    step();
    chk_en = 1;
    step();
    rst_n = 1;
    // default divide, lock then pulses every 4 cycles
    idle(90);
    // ch0 div3 ph2, ch1 div0, others 4
    dvv = '0;
    phv = '0;
    for (int i = 0; i < NC; i++) dvv[i*DW +: DW] = DW'(4);
    dvv[0 +: DW] = DW'(3);
    phv[0 +: DW] = DW'(2);
    dvv[DW +: DW] = '0;
    cyc(0, 0, 1, dvv, phv);
    idle(85);
    // phase beyond divide clamps to D-1
    dvv[2*DW +: DW] = DW'(5);
    phv[2*DW +: DW] = DW'(7);
    cyc(0, 0, 1, dvv, phv);
    idle(85);
    // power-down, with a config accepted on entry
    dvv[3*DW +: DW] = DW'(6);
    phv[3*DW +: DW] = DW'(5);
    cyc(1, 0, 1, dvv, phv);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, '0, '0);
    idle(80);
    // pll_rst, then again mid-lock
    cyc(0, 1, 0, '0, '0);
    idle(40);
    cyc(0, 1, 0, '0, '0);
    idle(80);
    // reset mid-operation discards config
    rst_n = 0;
    step();
    rst_n = 1;
    idle(80);
    // random traffic
    pd_left = 0;
    for (int n = 0; n < 6000; n++) begin
      rst_n = ($urandom_range(0, 1999) != 0);
      if (pd_left == 0 && $urandom_range(0, 299) == 0)
        pd_left = $urandom_range(1, 12);
      pwrdwn = (pd_left != 0);
      if (pd_left != 0) pd_left--;
      pll_rst = ($urandom_range(0, 249) == 0);
      cfg_if.cfg_valid = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NC; i++) begin
        cfg_if.cfg_div[i*DW +: DW] =
          DW'($urandom_range(0, 9));
        cfg_if.cfg_phase[i*DW +: DW] =
          DW'($urandom_range(0, 11));
      end
      step();
    end
    rst_n = 1;
    idle(90);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
